alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//   Arm/disarm controller for the 4-zone intrusion sensor path. Synchronises raw
//   zone inputs, applies a per-zone enable mask, runs exit/entry delays and a
//   bounded siren period, and latches which zones tripped. Sits between the
//   ui_in zone pins / keypad strobes and the uo_out siren and status pins.
// PARAMETERS
//   PRESCALE     1000  clk cycles per delay tick (>=2)
//   EXIT_TICKS   30    ticks in EXIT_DELAY before ARMED (>=1)
//   ENTRY_TICKS  15    ticks in ENTRY_DELAY before ALARM (>=1)
//   SIREN_TICKS  60    ticks siren stays on before auto re-arm (>=1)
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active high
//   zone_raw     in   4  raw sensor levels, async, 1 = open; bit0 = entry door
//   zone_mask    in   4  1 = zone monitored; sampled each cycle
//   arm_req      in   1  one-cycle arm strobe
//   disarm_req   in   1  one-cycle disarm strobe
//   siren        out  1  registered siren drive
//   armed        out  1  1 in EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM
//   state        out  3  current FSM state code (alarm_pkg)
//   zone_latched out 4  zones that caused ENTRY_DELAY/ALARM since last arm
// BEHAVIOUR
//   Reset: state=DISARMED, siren=0, armed=0, zone_latched=0, tick counter and
//     delay counter 0, synchroniser flops 0. All outputs registered.
//   Sync: zone_raw -> 2-flop synchroniser -> zone_s. trip = zone_s & zone_mask.
//   Tick: single-cycle pulse every PRESCALE clks; prescaler free-runs from reset,
//     is NOT realigned on state change (delay accuracy is -1 tick/+0).
//   Delay counter: loaded on state entry, decremented on tick, expiry when it
//     is 1 and tick is high. Width = $clog2(max ticks + 1).
//   States/transitions (evaluated every clk, priority top-down):
//   - any state, disarm_req=1 -> DISARMED; siren=0 next cycle. Disarm beats arm.
//   - DISARMED: arm_req -> EXIT_DELAY, cnt=EXIT_TICKS, zone_latched cleared.
//   - EXIT_DELAY: trips ignored; expiry -> ARMED. arm_req ignored.
//   - ARMED: trip[3:1]!=0 -> ALARM (instant zones); else trip[0] -> ENTRY_DELAY,
//     cnt=ENTRY_TICKS. zone_latched |= trip on the transition cycle.
//   - ENTRY_DELAY: trip[3:1]!=0 -> ALARM immediately; expiry -> ALARM.
//     zone_latched |= trip every cycle in this state.
//   - ALARM: siren=1, cnt=SIREN_TICKS on entry; zone_latched |= trip;
//     expiry -> ARMED, siren=0 (re-arm; zone still open re-trips next cycle).
//   Latency: instant zone rising in ARMED -> siren high 3 clk edges later
//     (2 sync + 1 state register).
//   Masked zones never trip; mask change takes effect the same cycle.
//   zone_latched held through DISARMED; cleared only by rst or next arm.
//   Reset mid-operation (any state, any counter value) -> reset values above
//     on the next edge; no pending strobes retained.
//   arm_req/disarm_req longer than 1 cycle act as repeated strobes (harmless).
// STRUCTURE
//   alarm_pkg: state codes DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3,
//     ALARM=4; ZONE_W=4; ENTRY_ZONE=0.
//   Sub-module alarm_tick_gen (PRESCALE) -> tick; FSM, counter, sync, latch
//   stay in alarm_sequencer.
// TESTING  (PRESCALE=4, EXIT_TICKS=3, ENTRY_TICKS=2, SIREN_TICKS=5, mask=4'hF)
//   Reset: hold rst 2 clk with zone_raw=4'hF -> state=0, siren=0, armed=0,
//     zone_latched=0 afterwards; stays DISARMED with zones open.
//   Arm/exit: arm_req pulse -> state=1, armed=1; zone_raw=4'h2 during exit
//     ignored; state=2 within 9..12 clk of the arm strobe; no siren.
//   Instant zone: ARMED, zone_raw=4'h4 -> siren=1 on 3rd edge, state=4,
//     zone_latched=4'h4; siren drops, state=2 within 17..20 clk of ALARM entry.
//   Entry delay: ARMED, zone_raw=4'h1 -> state=3; disarm_req within 4 clk ->
//     state=0, siren never 1, zone_latched=4'h1 retained.
//   Entry expiry + mask: mask=4'hD, zone_raw=4'h3 in ARMED -> state=3 (zone1
//     masked), ALARM after 2 ticks, zone_latched=4'h1.
//   Priority/reset: arm_req and disarm_req same cycle in DISARMED -> stays 0;
//     rst asserted in ALARM -> siren=0, state=0 next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Brief    : Shared state codes, zone constants and helpers for the
//            alarm_sequencer block.
// Revision : 1.0  initial release
// ============================================================================
package alarm_pkg;

  localparam int ZONE_W     = 4;
  localparam int ENTRY_ZONE = 0;

  // State codes are visible on the state output, so the encoding is fixed.
  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_e;

  // Largest of the three delay lengths; sizes the shared delay counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_sequencer_if
// Brief    : Zone/keypad inputs and siren/status outputs of alarm_sequencer.
//            master = keypad/sensor side, slave = sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface alarm_sequencer_if;

  logic [alarm_pkg::ZONE_W-1:0] zone_raw;
  logic [alarm_pkg::ZONE_W-1:0] zone_mask;
  logic                         arm_req;
  logic                         disarm_req;
  logic                         siren;
  logic                         armed;
  logic [2:0]                   state;
  logic [alarm_pkg::ZONE_W-1:0] zone_latched;

  modport master (
    output zone_raw, zone_mask, arm_req, disarm_req,
    input  siren, armed, state, zone_latched
  );

  modport slave (
    input  zone_raw, zone_mask, arm_req, disarm_req,
    output siren, armed, state, zone_latched
  );

endinterface
`default_nettype wire

// File: rtl/alarm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : alarm_tick_gen
// Brief    : Free-running prescaler; one-cycle tick every PRESCALE clocks.
//            Never realigned to FSM activity, so delays are -1/+0 ticks.
// Revision : 1.0  initial release
// ============================================================================
module alarm_tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  wire logic clk,
  input  wire logic rst,
  output logic      tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..PRESCALE-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + CW'(1);
  end

  assign tick_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alarm_sequencer
// Brief    : Arm/disarm controller for 4 intrusion zones: input synchroniser,
//            zone mask, exit/entry delays, bounded siren, tripped-zone latch.
// Revision : 1.0  initial release
// ============================================================================
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int PRESCALE    = 1000,
  parameter int EXIT_TICKS  = 30,
  parameter int ENTRY_TICKS = 15,
  parameter int SIREN_TICKS = 60
) (
  input  wire logic          clk,
  input  wire logic          rst,
  alarm_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(max3(EXIT_TICKS, ENTRY_TICKS, SIREN_TICKS) + 1);
  localparam logic [CNT_W-1:0] C_EXIT  = CNT_W'(EXIT_TICKS);
  localparam logic [CNT_W-1:0] C_ENTRY = CNT_W'(ENTRY_TICKS);
  localparam logic [CNT_W-1:0] C_SIREN = CNT_W'(SIREN_TICKS);

  logic [ZONE_W-1:0] sync1_q;
  logic [ZONE_W-1:0] zone_s_q;
  logic [ZONE_W-1:0] latched_q;
  logic [CNT_W-1:0]  cnt_q;
  state_e            state_q;
  logic              siren_q;
  logic              armed_q;

  logic              tick;
  logic [ZONE_W-1:0] trip;
  logic              instant_trip;
  logic              entry_trip;
  logic              expire;

  alarm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Two-flop synchroniser for the asynchronous sensor levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      zone_s_q <= '0;
    end else begin
      sync1_q  <= bus.zone_raw;
      zone_s_q <= sync1_q;
    end
  end

  // Mask is applied combinationally so a mask change acts the same cycle.
  assign trip         = zone_s_q & bus.zone_mask;
  assign instant_trip = |trip[ZONE_W-1:1];
  assign entry_trip   = trip[ENTRY_ZONE];
  assign expire       = tick && (cnt_q == CNT_W'(1));

  // Main FSM with delay counter, zone latch and registered siren/armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DISARMED;
      cnt_q     <= '0;
      latched_q <= '0;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      // Default countdown; a state entry below reloads it instead.
      if (tick && (cnt_q != '0)) cnt_q <= cnt_q - CNT_W'(1);

      if (bus.disarm_req) begin
        state_q <= DISARMED;
        siren_q <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          DISARMED: begin
            if (bus.arm_req) begin
              state_q   <= EXIT_DELAY;
              cnt_q     <= C_EXIT;
              latched_q <= '0;
              armed_q   <= 1'b1;
            end
          end
          EXIT_DELAY: begin
            if (expire) state_q <= ARMED;
          end
          ARMED: begin
            if (instant_trip) begin
              state_q   <= ALARM;
              cnt_q     <= C_SIREN;
              siren_q   <= 1'b1;
              latched_q <= latched_q | trip;
            end else if (entry_trip) begin
              state_q   <= ENTRY_DELAY;
              cnt_q     <= C_ENTRY;
              latched_q <= latched_q | trip;
            end
          end
          ENTRY_DELAY: begin
            latched_q <= latched_q | trip;
            if (instant_trip || expire) begin
              state_q <= ALARM;
              cnt_q   <= C_SIREN;
              siren_q <= 1'b1;
            end
          end
          ALARM: begin
            latched_q <= latched_q | trip;
            // Re-arm; a zone still open re-trips on the following cycle.
            if (expire) begin
              state_q <= ARMED;
              siren_q <= 1'b0;
            end
          end
          default: begin
            state_q <= DISARMED;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.siren        = siren_q;
  assign bus.armed        = armed_q;
  assign bus.state        = state_q;
  assign bus.zone_latched = latched_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_sequencer
// Brief    : Directed + randomized bench for alarm_sequencer against a
//            tick-counting behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alarm_sequencer;

  localparam int P  = 4;
  localparam int EX = 3;
  localparam int EN = 2;
  localparam int SI = 5;

  localparam int S_DIS = 0, S_EXIT = 1, S_ARMED = 2, S_ENTRY = 3, S_ALARM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_sequencer_if ifc ();

  alarm_sequencer #(
    .PRESCALE    (P),
    .EXIT_TICKS  (EX),
    .ENTRY_TICKS (EN),
    .SIREN_TICKS (SI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remaining-tick countdown plus a two-deep sample history for the sync.
  int         m_state = 0;
  int         m_rem   = 0;
  int         m_phase = 0;
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lat = '0;
  bit         m_valid = 0;
  logic [3:0] m_trip;
  bit         m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_state = S_DIS; m_rem = 0; m_phase = 0;
      m_s1 = '0; m_s2 = '0; m_lat = '0; m_valid = 1;
    end else begin
      m_trip = m_s2 & ifc.zone_mask;
      m_tick = (m_phase == P - 1);
      if (ifc.disarm_req) m_state = S_DIS;
      else begin
        case (m_state)
          S_DIS: if (ifc.arm_req) begin m_state = S_EXIT; m_rem = EX; m_lat = '0; end
          S_EXIT: if (m_tick) begin m_rem--; if (m_rem == 0) m_state = S_ARMED; end
          S_ARMED: begin
            if (m_trip[3:1] != 0) begin m_state = S_ALARM; m_rem = SI; m_lat |= m_trip; end
            else if (m_trip[0]) begin m_state = S_ENTRY; m_rem = EN; m_lat |= m_trip; end
          end
          S_ENTRY: begin
            m_lat |= m_trip;
            if (m_trip[3:1] != 0) begin m_state = S_ALARM; m_rem = SI; end
            else if (m_tick) begin
              m_rem--;
              if (m_rem == 0) begin m_state = S_ALARM; m_rem = SI; end
            end
          end
          default: begin // alarm
            m_lat |= m_trip;
            if (m_tick) begin m_rem--; if (m_rem == 0) m_state = S_ARMED; end
          end
        endcase
      end
      m_phase = (m_phase + 1) % P;
      m_s2 = m_s1;
      m_s1 = ifc.zone_raw;
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_state", 32'(ifc.state), 32'(m_state));
      chk("cyc_siren", 32'(ifc.siren), 32'(m_state == S_ALARM));
      chk("cyc_armed", 32'(ifc.armed), 32'(m_state != S_DIS));
      chk("cyc_latch", 32'(ifc.zone_latched), 32'(m_lat));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int target, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      step();
      n++;
      if (int'(ifc.state) == target) break;
    end
  endtask

  task automatic pulse_arm();
    ifc.arm_req = 1'b1; step(); ifc.arm_req = 1'b0;
  endtask

  task automatic pulse_disarm();
    ifc.disarm_req = 1'b1; step(); ifc.disarm_req = 1'b0;
  endtask

  int n;

  initial begin
    ifc.zone_raw   = 4'hF;
    ifc.zone_mask  = 4'hF;
    ifc.arm_req    = 1'b0;
    ifc.disarm_req = 1'b0;

    // Reset with all zones open
    rst = 1'b1;
    step(); step();
    chk("rst_state", 32'(ifc.state), 0);
    chk("rst_siren", 32'(ifc.siren), 0);
    chk("rst_armed", 32'(ifc.armed), 0);
    chk("rst_latch", 32'(ifc.zone_latched), 0);
    chk("model_rst_state", 32'(m_state), 0);
    rst = 1'b0;
    repeat (6) step();
    chk("rst_stay_disarmed", 32'(ifc.state), 0);
    chk("rst_stay_latch", 32'(ifc.zone_latched), 0);

    // Arm / exit delay; zone1 open early in exit is ignored
    ifc.zone_raw = 4'h0;
    pulse_arm();
    chk("exit_state", 32'(ifc.state), 1);
    chk("exit_armed", 32'(ifc.armed), 1);
    ifc.zone_raw = 4'h2;
    repeat (4) step();
    ifc.zone_raw = 4'h0;
    wait_state(S_ARMED, 20, n);
    chk("exit_window_9_12", 32'((n + 4 >= 9) && (n + 4 <= 12)), 1);
    chk("exit_no_siren", 32'(ifc.siren), 0);
    chk("exit_latch_clear", 32'(ifc.zone_latched), 0);

    // Instant zone: siren on the 3rd edge
    ifc.zone_raw = 4'h4;
    step(); chk("inst_edge1_siren", 32'(ifc.siren), 0);
    step(); chk("inst_edge2_siren", 32'(ifc.siren), 0);
    step(); chk("inst_edge3_siren", 32'(ifc.siren), 1);
    chk("inst_state", 32'(ifc.state), 4);
    chk("inst_latch", 32'(ifc.zone_latched), 4'h4);
    ifc.zone_raw = 4'h0;
    wait_state(S_ARMED, 25, n);
    chk("siren_window_17_20", 32'((n >= 17) && (n <= 20)), 1);
    chk("siren_dropped", 32'(ifc.siren), 0);

    // Entry delay aborted by disarm
    pulse_disarm();
    pulse_arm();
    wait_state(S_ARMED, 20, n);
    chk("rearm_ok", 32'(ifc.state), 2);
    ifc.zone_raw = 4'h1;
    repeat (3) step();
    chk("entry_state", 32'(ifc.state), 3);
    pulse_disarm();
    ifc.zone_raw = 4'h0;
    chk("entry_disarm_state", 32'(ifc.state), 0);
    chk("entry_disarm_siren", 32'(ifc.siren), 0);
    chk("entry_latch_kept", 32'(ifc.zone_latched), 4'h1);

    // Entry expiry with zone1 masked
    ifc.zone_mask = 4'hD;
    pulse_arm();
    wait_state(S_ARMED, 20, n);
    ifc.zone_raw = 4'h3;
    repeat (3) step();
    chk("mask_entry_state", 32'(ifc.state), 3);
    wait_state(S_ALARM, 12, n);
    chk("entry_expiry_5_8", 32'((n >= 5) && (n <= 8)), 1);
    chk("mask_latch", 32'(ifc.zone_latched), 4'h1);
    ifc.zone_raw = 4'h0;

    // Disarm beats arm
    pulse_disarm();
    ifc.arm_req = 1'b1; ifc.disarm_req = 1'b1;
    step();
    ifc.arm_req = 1'b0; ifc.disarm_req = 1'b0;
    chk("prio_state", 32'(ifc.state), 0);
    step();
    chk("prio_state_hold", 32'(ifc.state), 0);

    // Reset while in ALARM
    ifc.zone_mask = 4'hF;
    pulse_arm();
    wait_state(S_ARMED, 20, n);
    ifc.zone_raw = 4'h4;
    wait_state(S_ALARM, 6, n);
    chk("pre_rst_siren", 32'(ifc.siren), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifc.zone_raw = 4'h0;
    chk("mid_rst_state", 32'(ifc.state), 0);
    chk("mid_rst_siren", 32'(ifc.siren), 0);
    chk("mid_rst_latch", 32'(ifc.zone_latched), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  ifc.zone_raw  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) ifc.zone_mask = 4'($urandom_range(0, 15));
      ifc.arm_req    = ($urandom_range(0, 9) == 0);
      ifc.disarm_req = ($urandom_range(0, 59) == 0);
      rst            = ($urandom_range(0, 699) == 0);
      step();
    end
    ifc.arm_req = 1'b0; ifc.disarm_req = 1'b0; rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
